// File: rtl/tcam_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cam_defs
//  Description : Shared types for the TCAM request/response controller.
//                tcam_op_e         - command opcodes carried on req_op
//                tcam_status_e     - response codes carried on resp_status
//                tcam_ctrl_state_e - controller FSM states
//  Revision    : 1.0  initial release
// ============================================================================
package cam_defs;

   typedef enum logic [1:0] {
      OP_SEARCH = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_RSVD   = 2'd3
   } tcam_op_e;

   typedef enum logic [1:0] {
      STS_OK   = 2'd0,
      STS_MISS = 2'd1,
      STS_FULL = 2'd2,
      STS_ERR  = 2'd3
   } tcam_status_e;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_EXEC = 2'd2,
      ST_RESP = 2'd3
   } tcam_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/tcam_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : tcam_ctrl_if
//  Description : Command/response handshake bundle of the TCAM controller.
//  Signals     : req_valid/req_ready   command handshake
//                req_op, req_key, req_mask, req_idx   command payload
//                resp_valid/resp_ready response handshake
//                resp_status, resp_idx response payload
//  Modports    : master - client issuing commands
//                slave  - controller serving commands
//  Revision    : 1.0  initial release
// ============================================================================
interface tcam_ctrl_if #(
   parameter int TCAM_WIDTH = 32,
   parameter int IDX_W      = 4
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [TCAM_WIDTH-1:0] req_key;
   logic [TCAM_WIDTH-1:0] req_mask;
   logic [IDX_W-1:0]      req_idx;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [1:0]            resp_status;
   logic [IDX_W-1:0]      resp_idx;

   modport master (
      output req_valid, req_op, req_key, req_mask, req_idx, resp_ready,
      input  req_ready, resp_valid, resp_status, resp_idx
   );

   modport slave (
      input  req_valid, req_op, req_key, req_mask, req_idx, resp_ready,
      output req_ready, resp_valid, resp_status, resp_idx
   );

endinterface
`default_nettype wire

// File: rtl/prior_mux.sv
`default_nettype none
// ============================================================================
//  Module      : prior_mux
//  Description : Lowest-index priority selector.
//  Ports       : req   in  MUX_WIDTH  request vector
//                found out 1          at least one request bit set
//                idx   out SEL_W      index of the lowest set bit (0 if none)
//  Revision    : 1.0  initial release
// ============================================================================
module prior_mux #(
   parameter int  MUX_WIDTH = 16,
   localparam int SEL_W     = (MUX_WIDTH > 1) ? $clog2(MUX_WIDTH) : 1
) (
   input  logic [MUX_WIDTH-1:0] req,
   output logic                 found,
   output logic [SEL_W-1:0]     idx
);

   // Scanning from the top down lets the lowest set bit overwrite last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = MUX_WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = SEL_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tcam.sv
`default_nettype none
// ============================================================================
//  Module      : tcam
//  Description : Behavioural ternary CAM. One write port, one combinational
//                masked search of the current data_i/data_mask; the lowest
//                matching entry wins.
//  Ports       : clk        in  1      clock
//                data_we    in  1      write enable
//                data_idx   in  IDX_W  write index
//                data_i     in  WIDTH  write data / search key
//                data_mask  in  WIDTH  search mask, 1 = bit compared
//                index_rdy  out 1      some entry matches
//                index_o    out IDX_W  lowest matching entry
//  Revision    : 1.0  initial release
// ============================================================================
module tcam #(
   parameter int  TCAM_WIDTH = 32,
   parameter int  TCAM_DEPTH = 16,
   localparam int IDX_W      = $clog2(TCAM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  data_we,
   input  logic [IDX_W-1:0]      data_idx,
   input  logic [TCAM_WIDTH-1:0] data_i,
   input  logic [TCAM_WIDTH-1:0] data_mask,
   output logic                  index_rdy,
   output logic [IDX_W-1:0]      index_o
);

   logic [TCAM_WIDTH-1:0] r_entry [TCAM_DEPTH];
   logic [TCAM_DEPTH-1:0] w_match;

   // Storage is array-like and is brought to a known state by the
   // controller's init sweep, so it carries no reset.
   always_ff @(posedge clk) begin
      if (data_we) begin
         r_entry[data_idx] <= data_i;
      end
   end

   for (genvar g = 0; g < TCAM_DEPTH; g++) begin : g_match
      assign w_match[g] = (((r_entry[g] ^ data_i) & data_mask) == '0);
   end

   prior_mux #(
      .MUX_WIDTH (TCAM_DEPTH)
   ) u_match_sel (
      .req   (w_match),
      .found (index_rdy),
      .idx   (index_o)
   );

endmodule
`default_nettype wire

// File: rtl/tcam_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tcam_ctrl
//  Description : Request/response front-end owning one tcam. Serves SEARCH,
//                INSERT and DELETE commands, keeps a valid bitmap with a free
//                counter, allocates the lowest free slot and frees entries by
//                overwriting them with DEAD_KEY. On reset the whole array is
//                swept with DEAD_KEY before commands are accepted.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                bus (slave)         command/response handshake
//                tcam_data_we/idx/i/mask  write/search port to the tcam
//                tcam_index_rdy/o    combinational match result from the tcam
//                init_done           init sweep finished
//                free_count          number of invalid entries
//  Revision    : 1.0  initial release
// ============================================================================
module tcam_ctrl
   import cam_defs::*;
#(
   parameter int                    TCAM_WIDTH = 32,
   parameter int                    TCAM_DEPTH = 16,
   parameter logic [TCAM_WIDTH-1:0] DEAD_KEY   = '1,
   localparam int                   IDX_W      = $clog2(TCAM_DEPTH),
   localparam int                   CNT_W      = $clog2(TCAM_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   tcam_ctrl_if.slave            bus,
   output logic                  tcam_data_we,
   output logic [IDX_W-1:0]      tcam_data_idx,
   output logic [TCAM_WIDTH-1:0] tcam_data_i,
   output logic [TCAM_WIDTH-1:0] tcam_data_mask,
   input  logic                  tcam_index_rdy,
   input  logic [IDX_W-1:0]      tcam_index_o,
   output logic                  init_done,
   output logic [CNT_W-1:0]      free_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TCAM_DEPTH - 1);

   tcam_ctrl_state_e      r_state;
   tcam_ctrl_state_e      w_state_nxt;
   logic [IDX_W-1:0]      r_init_idx;
   logic                  r_init_done;
   tcam_op_e              r_op;
   logic [TCAM_WIDTH-1:0] r_key;
   logic [TCAM_WIDTH-1:0] r_mask;
   logic [IDX_W-1:0]      r_idx;
   logic [TCAM_DEPTH-1:0] r_valid;
   logic [CNT_W-1:0]      r_free_count;
   tcam_status_e          r_status;
   logic [IDX_W-1:0]      r_resp_idx;

   logic [TCAM_DEPTH-1:0] w_free_map;
   logic                  w_free_found;
   logic [IDX_W-1:0]      w_free_idx;
   logic                  w_ins_ok;
   logic                  w_del_ok;
   tcam_status_e          w_status;
   logic [IDX_W-1:0]      w_idx;

   // ------------------------------------------------------------------
   // Free-slot selection: lowest clear bit of the valid bitmap.
   // ------------------------------------------------------------------
   assign w_free_map = ~r_valid;

   prior_mux #(
      .MUX_WIDTH (TCAM_DEPTH)
   ) u_free_sel (
      .req   (w_free_map),
      .found (w_free_found),
      .idx   (w_free_idx)
   );

   // free_count always equals popcount(~valid), so "some bit free" and
   // "free_count != 0" are the same condition.
   assign w_ins_ok = w_free_found;
   assign w_del_ok = r_valid[r_idx];

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: if (r_init_idx == LAST_IDX) w_state_nxt = ST_IDLE;
         ST_IDLE: if (bus.req_valid)          w_state_nxt = ST_EXEC;
         ST_EXEC:                             w_state_nxt = ST_RESP;
         ST_RESP: if (bus.resp_ready)         w_state_nxt = ST_IDLE;
         default:                             w_state_nxt = ST_INIT;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs. Everything is forced idle while rst is high so the
   // array is never written before the sweep actually starts.
   // ------------------------------------------------------------------
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      tcam_data_we   = 1'b0;
      tcam_data_idx  = '0;
      tcam_data_i    = '0;
      tcam_data_mask = '0;
      if (!rst) begin
         case (r_state)
            ST_INIT: begin
               tcam_data_we  = 1'b1;
               tcam_data_idx = r_init_idx;
               tcam_data_i   = DEAD_KEY;
            end
            ST_IDLE: bus.req_ready = 1'b1;
            ST_EXEC: begin
               case (r_op)
                  OP_SEARCH: begin
                     tcam_data_i    = r_key;
                     tcam_data_mask = r_mask;
                  end
                  OP_INSERT: begin
                     if (w_ins_ok) begin
                        tcam_data_we  = 1'b1;
                        tcam_data_idx = w_free_idx;
                        tcam_data_i   = r_key;
                     end
                  end
                  OP_DELETE: begin
                     if (w_del_ok) begin
                        tcam_data_we  = 1'b1;
                        tcam_data_idx = r_idx;
                        tcam_data_i   = DEAD_KEY;
                     end
                  end
                  default: ;
               endcase
            end
            ST_RESP: bus.resp_valid = 1'b1;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Response decode for the command in EXEC. A search hit must also land
   // on a valid entry; freed entries only hold DEAD_KEY.
   // ------------------------------------------------------------------
   always_comb begin
      w_status = STS_OK;
      w_idx    = '0;
      case (r_op)
         OP_SEARCH: begin
            if (tcam_index_rdy && r_valid[tcam_index_o]) begin
               w_idx = tcam_index_o;
            end else begin
               w_status = STS_MISS;
            end
         end
         OP_INSERT: begin
            if (w_ins_ok) begin
               w_idx = w_free_idx;
            end else begin
               w_status = STS_FULL;
            end
         end
         OP_DELETE: begin
            if (w_del_ok) begin
               w_idx = r_idx;
            end else begin
               w_status = STS_ERR;
            end
         end
         default: w_status = STS_ERR;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_init_idx   <= '0;
         r_init_done  <= 1'b0;
         r_op         <= OP_SEARCH;
         r_key        <= '0;
         r_mask       <= '0;
         r_idx        <= '0;
         r_valid      <= '0;
         r_free_count <= CNT_W'(TCAM_DEPTH);
         r_status     <= STS_OK;
         r_resp_idx   <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_init_idx == LAST_IDX) begin
                  r_init_idx  <= '0;
                  r_init_done <= 1'b1;
               end else begin
                  r_init_idx <= r_init_idx + IDX_W'(1);
               end
            end
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_op   <= tcam_op_e'(bus.req_op);
                  r_key  <= bus.req_key;
                  r_mask <= bus.req_mask;
                  r_idx  <= bus.req_idx;
               end
            end
            ST_EXEC: begin
               r_status   <= w_status;
               r_resp_idx <= w_idx;
               // Bitmap and counter move on the same edge as the tcam write.
               if (r_op == OP_INSERT && w_ins_ok) begin
                  r_valid[w_free_idx] <= 1'b1;
                  r_free_count        <= r_free_count - CNT_W'(1);
               end
               if (r_op == OP_DELETE && w_del_ok) begin
                  r_valid[r_idx] <= 1'b0;
                  r_free_count   <= r_free_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.resp_status = r_status;
   assign bus.resp_idx    = r_resp_idx;
   assign init_done       = r_init_done;
   assign free_count      = r_free_count;

endmodule
`default_nettype wire

// File: tb/tb_tcam_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcam_ctrl
//  Description : Self-checking bench for tcam_ctrl + tcam. Directed scenarios
//                followed by random commands checked against an array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tcam_ctrl;

   localparam int W  = 32;
   localparam int D  = 16;
   localparam int IW = 4;
   localparam int CW = 5;
   localparam logic [W-1:0] DEAD  = '1;
   localparam logic [W-1:0] FULLM = '1;
   localparam logic [1:0] SEARCH = 2'd0, INSERT = 2'd1, DELETE = 2'd2, RSVD = 2'd3;
   localparam logic [1:0] R_OK = 2'd0, R_MISS = 2'd1, R_FULL = 2'd2, R_ERR = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tcam_ctrl_if #(.TCAM_WIDTH(W), .IDX_W(IW)) bus ();

   logic          t_we;
   logic [IW-1:0] t_idx;
   logic [W-1:0]  t_di;
   logic [W-1:0]  t_dm;
   logic          t_rdy;
   logic [IW-1:0] t_io;
   logic          init_done;
   logic [CW-1:0] free_count;

   tcam_ctrl #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .tcam_data_we   (t_we),
      .tcam_data_idx  (t_idx),
      .tcam_data_i    (t_di),
      .tcam_data_mask (t_dm),
      .tcam_index_rdy (t_rdy),
      .tcam_index_o   (t_io),
      .init_done      (init_done),
      .free_count     (free_count)
   );

   tcam #(.TCAM_WIDTH(W), .TCAM_DEPTH(D)) u_tcam (
      .clk       (clk),
      .data_we   (t_we),
      .data_idx  (t_idx),
      .data_i    (t_di),
      .data_mask (t_dm),
      .index_rdy (t_rdy),
      .index_o   (t_io)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: which slots hold a live key, and what they hold.
   logic          m_valid [D];
   logic [W-1:0]  m_key   [D];

   // Observations of the most recent command.
   logic [1:0]    o_st;
   logic [IW-1:0] o_idx;
   int            acc_cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int m_free();
      int n = 0;
      for (int i = 0; i < D; i++) if (!m_valid[i]) n++;
      return n;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < D; i++) begin
         m_valid[i] = 1'b0;
         m_key[i]   = DEAD;
      end
   endtask

   // Called at a negedge with rst already high for at least one edge.
   task automatic reset_init();
      chk("rst_outputs", 64'({bus.req_ready, bus.resp_valid, bus.resp_status, bus.resp_idx, t_we, init_done}), 64'(0));
      chk("rst_free_count", 64'(free_count), 64'(D));
      // A request during the sweep must be ignored.
      bus.req_valid = 1'b1;
      bus.req_op    = INSERT;
      bus.req_key   = 32'h5555_0000;
      rst = 1'b0;
      #1;
      for (int k = 0; k < D; k++) begin
         chk("init_sweep", 64'({t_we, t_idx, t_di == DEAD, t_dm, bus.req_ready, init_done}),
             64'({1'b1, IW'(k), 1'b1, 32'h0, 1'b0, 1'b0}));
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      chk("init_end", 64'({init_done, bus.req_ready, t_we, free_count}), 64'({1'b1, 1'b1, 1'b0, CW'(D)}));
      m_clear();
   endtask

   // Issue one command from a negedge with the controller idle; returns at
   // the negedge after the response handshake.
   task automatic cmd(input logic [1:0] op, input logic [W-1:0] key, input logic [W-1:0] mask,
                      input logic [IW-1:0] idx, input int hold);
      logic [1:0]    e_st;
      logic [IW-1:0] e_idx;
      logic          e_we;
      logic [W-1:0]  e_di, e_dm;
      int            n;
      e_st = R_OK; e_idx = '0; e_we = 1'b0; e_di = '0; e_dm = '0;
      case (op)
         SEARCH: begin
            e_st = R_MISS; e_di = key; e_dm = mask;
            for (int i = 0; i < D; i++)
               if (e_st == R_MISS && m_valid[i] && ((m_key[i] ^ key) & mask) == '0) begin
                  e_st = R_OK; e_idx = IW'(i);
               end
         end
         INSERT: begin
            e_st = R_FULL;
            for (int i = 0; i < D; i++)
               if (e_st == R_FULL && !m_valid[i]) begin
                  e_st = R_OK; e_idx = IW'(i);
               end
            if (e_st == R_OK) begin e_we = 1'b1; e_di = key; end
         end
         DELETE: begin
            if (m_valid[idx]) begin e_idx = idx; e_we = 1'b1; e_di = DEAD; end
            else e_st = R_ERR;
         end
         default: e_st = R_ERR;
      endcase

      bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key; bus.req_mask = mask; bus.req_idx = idx;
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      chk("req_ready", 64'(bus.req_ready), 64'(1));
      @(negedge clk);
      acc_cyc = cyc;
      // Inputs need not hold after acceptance; scramble them while in EXEC.
      bus.req_op = 2'($urandom); bus.req_key = $urandom; bus.req_mask = $urandom; bus.req_idx = IW'($urandom);
      chk("exec_write", 64'({t_we, t_we ? t_idx : 4'd0}), 64'({e_we, e_we ? e_idx : 4'd0}));
      chk("exec_data", 64'({t_di, t_dm}), 64'({e_di, e_dm}));
      chk("exec_quiet", 64'({bus.resp_valid, bus.req_ready}), 64'(0));
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
      chk("resp_latency", 64'(cyc - acc_cyc), 64'(1));
      chk("resp", 64'({bus.resp_valid, bus.resp_status, bus.resp_idx}), 64'({1'b1, e_st, e_idx}));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("resp_hold", 64'({bus.resp_valid, bus.req_ready, bus.resp_status, bus.resp_idx}),
             64'({1'b1, 1'b0, e_st, e_idx}));
      end
      o_st = bus.resp_status; o_idx = bus.resp_idx;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("resp_done", 64'({bus.resp_valid, bus.req_ready}), 64'({1'b0, 1'b1}));
      if (op == INSERT && e_st == R_OK) begin m_valid[e_idx] = 1'b1; m_key[e_idx] = key; end
      if (op == DELETE && e_st == R_OK) begin m_valid[e_idx] = 1'b0; m_key[e_idx] = DEAD; end
      chk("free_count", 64'(free_count), 64'(m_free()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int            prev;
      logic [W-1:0]  old_key;
      logic [1:0]    op;
      logic [W-1:0]  key, mask;
      int            j;
      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_key = '0; bus.req_mask = '0; bus.req_idx = '0;
      bus.resp_ready = 1'b0;
      m_clear();
      repeat (3) @(negedge clk);
      reset_init();

      // Insert and search
      cmd(INSERT, 32'h1234_5678, '0, '0, 0);
      chk("ins0", 64'({o_st, o_idx}), 64'({R_OK, 4'd0}));
      prev = acc_cyc;
      cmd(INSERT, 32'hABCD_0000, '0, '0, 0);
      chk("ins1", 64'({o_st, o_idx}), 64'({R_OK, 4'd1}));
      chk("accept_spacing", 64'(acc_cyc - prev), 64'(3));
      cmd(SEARCH, 32'hABCD_1111, 32'hFFFF_0000, '0, 0);
      chk("search_hit", 64'({o_st, o_idx}), 64'({R_OK, 4'd1}));
      cmd(SEARCH, 32'h0, FULLM, '0, 0);
      chk("search_miss", 64'(o_st), 64'(R_MISS));

      // Fill to full
      for (int i = 2; i < D; i++) begin
         cmd(INSERT, $urandom & 32'hFFFF_FFFE, '0, '0, 0);
         chk("fill_idx", 64'(o_idx), 64'(i));
      end
      chk("full_count", 64'(free_count), 64'(0));
      cmd(INSERT, 32'h0BAD_F00C, '0, '0, 0);
      chk("insert_full", 64'(o_st), 64'(R_FULL));

      // Delete and reuse
      old_key = m_key[3];
      cmd(DELETE, '0, '0, 4'd3, 0);
      chk("del3", 64'({o_st, o_idx, free_count}), 64'({R_OK, 4'd3, 5'd1}));
      cmd(SEARCH, old_key, FULLM, '0, 0);
      chk("search_deleted", 64'(o_st), 64'(R_MISS));
      cmd(INSERT, 32'h7777_0000, '0, '0, 0);
      chk("reuse3", 64'({o_st, o_idx}), 64'({R_OK, 4'd3}));
      cmd(DELETE, '0, '0, 4'd3, 0);
      chk("del3_again", 64'(o_st), 64'(R_OK));
      cmd(DELETE, '0, '0, 4'd3, 0);
      chk("del3_twice", 64'({o_st, o_idx}), 64'({R_ERR, 4'd0}));

      // Backpressure and reserved op
      cmd(SEARCH, 32'hABCD_0000, FULLM, '0, 5);
      chk("bp_search", 64'({o_st, o_idx}), 64'({R_OK, 4'd1}));
      cmd(INSERT, 32'h3333_3332, '0, '0, 5);
      cmd(RSVD, 32'h1234_5678, FULLM, 4'd0, 0);
      chk("reserved_op", 64'({o_st, o_idx}), 64'({R_ERR, 4'd0}));

      // Random traffic; keys keep bit 0 clear and masks keep it set so no
      // search can ever match a DEAD_KEY entry.
      for (int t = 0; t < 160; t++) begin
         j = $urandom_range(0, 9);
         op = (j < 4) ? SEARCH : (j < 7) ? INSERT : (j < 9) ? DELETE : RSVD;
         key  = $urandom & 32'hFFFF_FFFE;
         mask = $urandom | 32'h1;
         if (op == SEARCH && j < 2) begin
            j = $urandom_range(0, D - 1);
            if (m_valid[j]) key = m_key[j];
         end
         cmd(op, key, mask, IW'($urandom), $urandom_range(0, 3));
      end

      // Reset while a response is pending
      bus.req_valid = 1'b1; bus.req_op = SEARCH; bus.req_key = '0; bus.req_mask = FULLM;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("mid_resp_valid", 64'(bus.resp_valid), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("rst_drops_resp", 64'(bus.resp_valid), 64'(0));
      reset_init();
      cmd(SEARCH, 32'h1234_5678, FULLM, '0, 0);
      chk("post_rst_miss0", 64'(o_st), 64'(R_MISS));
      cmd(SEARCH, 32'hABCD_0000, FULLM, '0, 0);
      chk("post_rst_miss1", 64'(o_st), 64'(R_MISS));
      cmd(INSERT, 32'h4444_4444, '0, '0, 0);
      chk("post_rst_ins", 64'({o_st, o_idx}), 64'({R_OK, 4'd0}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
